// File: rtl/ball_physics_engine.sv
// Pong ball integrator: advances the ball once per accepted frame_tick, resolving
// wall bounces, paddle hits and scoring, with a timed pause at centre after a point.
module ball_physics_engine #(
  parameter int SCREEN_WIDTH       = 640,
  parameter int SCREEN_HEIGHT      = 480,
  parameter int BALL_SIZE          = 8,
  parameter int PADDLE_WIDTH       = 10,
  parameter int HALF_PADDLE_HEIGHT = 50,
  parameter int LEFT_PADDLE_X      = 20,
  parameter int RIGHT_PADDLE_X     = 610,
  parameter int INIT_VX            = 3,
  parameter int INIT_VY            = 2,
  parameter int SCORE_PAUSE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic [31:0] left_paddle_position,
  input  logic [31:0] right_paddle_position,
  output logic [31:0] ball_position,
  output logic [15:0] ball_velocity,
  output logic        update_valid,
  output logic        event_did_happen,
  output logic [1:0]  player_did_score
);

  localparam logic [15:0] CENTER_X     = 16'((SCREEN_WIDTH - BALL_SIZE) / 2);
  localparam logic [15:0] CENTER_Y     = 16'((SCREEN_HEIGHT - BALL_SIZE) / 2);
  localparam logic [15:0] FLOOR_Y      = 16'(SCREEN_HEIGHT - BALL_SIZE);
  localparam logic [15:0] LEFT_REST_X  = 16'(LEFT_PADDLE_X + PADDLE_WIDTH);
  localparam logic [15:0] RIGHT_REST_X = 16'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic [7:0]  SERVE_VX     = 8'(INIT_VX);
  localparam logic [7:0]  SERVE_VY     = 8'(INIT_VY);

  localparam logic signed [17:0] Y_LIMIT    = 18'(SCREEN_HEIGHT - BALL_SIZE);
  localparam logic signed [17:0] X_LIMIT    = 18'(SCREEN_WIDTH - BALL_SIZE);
  localparam logic signed [17:0] LEFT_FACE  = 18'(LEFT_PADDLE_X + PADDLE_WIDTH);
  localparam logic signed [17:0] RIGHT_FACE = 18'(RIGHT_PADDLE_X);
  localparam logic signed [17:0] BALL_SPAN  = 18'(BALL_SIZE);
  localparam logic signed [17:0] BALL_LAST  = 18'(BALL_SIZE - 1);
  localparam logic signed [17:0] HALF       = 18'(HALF_PADDLE_HEIGHT);
  localparam logic signed [17:0] ZERO       = 18'sd0;

  localparam int PW = (SCORE_PAUSE_FRAMES > 1) ? $clog2(SCORE_PAUSE_FRAMES) : 1;
  localparam logic [PW-1:0] PAUSE_LAST = PW'(SCORE_PAUSE_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    RESOLVE,
    PAUSE
  } state_t;

  state_t        state;
  logic [PW-1:0] pause_count;

  logic signed [7:0]  vx;
  logic signed [7:0]  vy;
  logic [7:0]         vx_mag;
  logic [7:0]         vy_mag;
  logic signed [17:0] x_cur;
  logic signed [17:0] nx;
  logic signed [17:0] ny;
  logic signed [17:0] left_py;
  logic signed [17:0] right_py;
  logic               left_overlap;
  logic               right_overlap;
  logic               left_hit;
  logic               right_hit;

  logic [15:0] next_x;
  logic [15:0] next_y;
  logic [7:0]  next_vx;
  logic [7:0]  next_vy;
  logic        next_event;
  logic [1:0]  next_score;
  logic        wall_bounce;

  // Paddle x coordinates are fixed by parameters; the x fields are informational only.
  logic unused_paddle_x;
  assign unused_paddle_x = ^{left_paddle_position[31:16], right_paddle_position[31:16]};

  assign vx       = ball_velocity[15:8];
  assign vy       = ball_velocity[7:0];
  assign vx_mag   = vx[7] ? (~ball_velocity[15:8] + 8'd1) : ball_velocity[15:8];
  assign vy_mag   = vy[7] ? (~ball_velocity[7:0] + 8'd1) : ball_velocity[7:0];
  assign x_cur    = {2'b00, ball_position[31:16]};
  assign nx       = x_cur + {{10{vx[7]}}, ball_velocity[15:8]};
  assign ny       = {2'b00, ball_position[15:0]} + {{10{vy[7]}}, ball_velocity[7:0]};
  assign left_py  = {2'b00, left_paddle_position[15:0]};
  assign right_py = {2'b00, right_paddle_position[15:0]};

  // Signed so that a paddle centred near y=0 still yields a sensible lower bound.
  assign left_overlap  = (ny <= left_py + HALF) && (ny + BALL_LAST >= left_py - HALF);
  assign right_overlap = (ny <= right_py + HALF) && (ny + BALL_LAST >= right_py - HALF);

  assign left_hit  = vx[7] && (x_cur >= LEFT_FACE) && (nx < LEFT_FACE) && left_overlap;
  assign right_hit = !vx[7] && (vx != 8'sd0) && (x_cur + BALL_SPAN <= RIGHT_FACE)
                     && (nx + BALL_SPAN > RIGHT_FACE) && right_overlap;

  always_comb begin
    next_x      = nx[15:0];
    next_y      = ny[15:0];
    next_vx     = ball_velocity[15:8];
    next_vy     = ball_velocity[7:0];
    next_score  = 2'b00;
    wall_bounce = 1'b0;

    if (ny <= ZERO) begin
      next_y      = 16'd0;
      next_vy     = vy_mag;
      wall_bounce = 1'b1;
    end else if (ny >= Y_LIMIT) begin
      next_y      = FLOOR_Y;
      next_vy     = ~vy_mag + 8'd1;
      wall_bounce = 1'b1;
    end

    if (left_hit) begin
      next_x  = LEFT_REST_X;
      next_vx = vx_mag;
    end else if (right_hit) begin
      next_x  = RIGHT_REST_X;
      next_vx = ~vx_mag + 8'd1;
    end else if (nx <= ZERO) begin
      next_score = 2'b10;
    end else if (nx >= X_LIMIT) begin
      next_score = 2'b01;
    end

    // A point re-serves from centre toward the player who just lost it.
    if (next_score != 2'b00) begin
      next_x  = CENTER_X;
      next_y  = CENTER_Y;
      next_vy = SERVE_VY;
      next_vx = next_score[0] ? SERVE_VX : (~SERVE_VX + 8'd1);
    end

    next_event = wall_bounce | left_hit | right_hit | (next_score != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      pause_count      <= '0;
      ball_position    <= {CENTER_X, CENTER_Y};
      ball_velocity    <= {SERVE_VX, SERVE_VY};
      update_valid     <= 1'b0;
      event_did_happen <= 1'b0;
      player_did_score <= 2'b00;
    end else begin
      update_valid     <= 1'b0;
      event_did_happen <= 1'b0;
      player_did_score <= 2'b00;

      case (state)
        IDLE: begin
          if (serve) state <= RUN;
        end
        RUN: begin
          if (frame_tick) state <= STEP;
        end
        STEP: begin
          ball_position    <= {next_x, next_y};
          ball_velocity    <= {next_vx, next_vy};
          update_valid     <= 1'b1;
          event_did_happen <= next_event;
          player_did_score <= next_score;
          state            <= RESOLVE;
        end
        RESOLVE: begin
          pause_count <= '0;
          state       <= (player_did_score != 2'b00) ? PAUSE : RUN;
        end
        PAUSE: begin
          if (frame_tick) begin
            if (pause_count == PAUSE_LAST) begin
              pause_count <= '0;
              state       <= RUN;
            end else begin
              pause_count <= pause_count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
